// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the commit-trace capture block: FSM states and entry width.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StPost   = 2'd2,
    StFrozen = 2'd3
  } state_e;

  function automatic int unsigned entry_w(input int unsigned addr_w, input int unsigned instr_w);
    return addr_w + instr_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: synchronous write, asynchronous read, no reset.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_trace_buffer.sv
// Circular (PC, instruction) trace capture with PC trigger, post-trigger window and drain port.
// Define PC_TRACE_FILTER_EN to record only control-flow discontinuities plus the trigger record.
module pc_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cap_en,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic               trig_arm,
  input  logic [ADDR_W-1:0]  trig_pc,
  input  logic [CNT_W-1:0]   post_cnt,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ADDR_W-1:0]  rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic               rd_last,
  output logic               busy,
  output logic               triggered,
  output logic               wrapped,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = entry_w(ADDR_W, INSTR_W);

  state_e             state_q;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, post_q, rd_rem_q;
  logic               triggered_q, wrapped_q;
  logic               rd_valid_q, rd_last_q;
  logic [ADDR_W-1:0]  rd_pc_q;
  logic [INSTR_W-1:0] rd_instr_q;

  logic             rec, pc_match, wr_en, arm_restart, full, freeze;
  logic [AW-1:0]    wr_addr, wr_ptr_d;
  logic [CNT_W-1:0] count_d;
  logic             wrapped_d;
  logic [EW-1:0]    wr_data, rd_data;

  assign pc_match = (pc == trig_pc);

`ifdef PC_TRACE_FILTER_EN
  assign rec = cap_en && ((next_pc != pc + ADDR_W'(4)) || pc_match);
`else
  logic unused_next_pc;
  assign unused_next_pc = ^next_pc;
  assign rec = cap_en;
`endif

  assign wr_en       = (state_q inside {StArmed, StPost}) && rec;
  assign arm_restart = trig_arm && (state_q != StFrozen);
  assign full        = (count_q == CNT_W'(DEPTH));

  // A write coincident with a restart lands in slot 0 of the fresh window.
  assign wr_addr = arm_restart ? '0 : wr_ptr_q;
  assign wr_data = {pc, instr};

  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(1);
    count_d   = full ? count_q : count_q + CNT_W'(1);
    wrapped_d = wrapped_q | full;
  end

  assign freeze = wr_en && !arm_restart &&
                  (((state_q == StArmed) && pc_match && (post_cnt == '0)) ||
                   ((state_q == StPost) && (post_q == CNT_W'(1))));

  trace_ram #(
    .DEPTH(DEPTH),
    .WIDTH(EW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wr_en),
    .waddr_i(wr_addr),
    .wdata_i(wr_data),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      post_q      <= '0;
      rd_rem_q    <= '0;
      triggered_q <= 1'b0;
      wrapped_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_pc_q     <= '0;
      rd_instr_q  <= '0;
    end else if (arm_restart) begin
      state_q     <= StArmed;
      triggered_q <= 1'b0;
      wrapped_q   <= 1'b0;
      wr_ptr_q    <= wr_en ? AW'(1) : '0;
      count_q     <= wr_en ? CNT_W'(1) : '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q  <= wr_ptr_d;
        count_q   <= count_d;
        wrapped_q <= wrapped_d;
      end
      unique case (state_q)
        StIdle: ;
        StArmed: begin
          if (wr_en && pc_match) begin
            triggered_q <= 1'b1;
            post_q      <= post_cnt;
            state_q     <= StPost;
          end
        end
        StPost: begin
          if (wr_en) begin
            post_q <= post_q - CNT_W'(1);
          end
        end
        StFrozen: begin
          if (rd_valid_q && rd_ready && rd_last_q) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            count_q    <= '0;
            state_q    <= StIdle;
          end else if ((!rd_valid_q || rd_ready) && (rd_rem_q != '0)) begin
            // rd_ptr_q runs one entry ahead of the beat being presented.
            rd_valid_q <= 1'b1;
            rd_pc_q    <= rd_data[EW-1 -: ADDR_W];
            rd_instr_q <= rd_data[INSTR_W-1:0];
            rd_last_q  <= (rd_rem_q == CNT_W'(1));
            rd_ptr_q   <= rd_ptr_q + AW'(1);
            rd_rem_q   <= rd_rem_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
      if (freeze) begin
        state_q  <= StFrozen;
        rd_ptr_q <= wrapped_d ? wr_ptr_d : '0;
        rd_rem_q <= count_d;
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign triggered = triggered_q;
  assign wrapped   = wrapped_q;
  assign count     = count_q;
  assign rd_valid  = rd_valid_q;
  assign rd_pc     = rd_pc_q;
  assign rd_instr  = rd_instr_q;
  assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Self-checking bench for pc_trace_buffer against a queue-based model of the trace window.
module tb_pc_trace_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, cap_en, trig_arm, rd_ready;
  logic [31:0] pc, instr, next_pc, trig_pc;
  logic [3:0]  post_cnt;
  logic        rd_valid, rd_last, busy, triggered, wrapped;
  logic [31:0] rd_pc, rd_instr;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t mq[$];
  bit   m_capturing, m_in_post, m_frozen, m_trig, m_wrapped;
  int   m_left;

  always #5 clk = ~clk;

  pc_trace_buffer #(
    .ADDR_W (32),
    .INSTR_W(32),
    .DEPTH  (DEPTH),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cap_en   (cap_en),
    .pc       (pc),
    .instr    (instr),
    .next_pc  (next_pc),
    .trig_arm (trig_arm),
    .trig_pc  (trig_pc),
    .post_cnt (post_cnt),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_pc    (rd_pc),
    .rd_instr (rd_instr),
    .rd_last  (rd_last),
    .busy     (busy),
    .triggered(triggered),
    .wrapped  (wrapped),
    .count    (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] ins);
    ent_t e;
    e.pc = p;
    e.instr = ins;
    mq.push_back(e);
    if (mq.size() > DEPTH) begin
      void'(mq.pop_front());
      m_wrapped = 1;
    end
  endtask

  task automatic freeze_model();
    m_capturing = 0;
    m_in_post = 0;
    m_frozen = 1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, busy, m_capturing || m_frozen);
    check({tag, "_triggered"}, triggered, m_trig);
    check({tag, "_wrapped"}, wrapped, m_wrapped);
    check({tag, "_count"}, count, mq.size());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; cap_en = 0; trig_arm = 0; rd_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    mq.delete();
    m_capturing = 0; m_in_post = 0; m_frozen = 0; m_trig = 0; m_wrapped = 0;
    check_status("reset");
    check("reset_rd_valid", rd_valid, 0);
  endtask

  task automatic step(input bit cap, input logic [31:0] p, input logic [31:0] npc, input bit arm);
    logic [31:0] ins;
    bit rec, was_cap, was_frozen;
    ins = $urandom;
    @(negedge clk);
    cap_en = cap; pc = p; instr = ins; next_pc = npc; trig_arm = arm;
`ifdef PC_TRACE_FILTER_EN
    rec = cap && ((npc != p + 32'd4) || (p == trig_pc));
`else
    rec = cap;
`endif
    was_cap = m_capturing;
    was_frozen = m_frozen;
    if (arm && !m_frozen) begin
      mq.delete();
      m_wrapped = 0; m_trig = 0; m_in_post = 0; m_capturing = 1;
      if (was_cap && rec) push(p, ins);
    end else if (m_capturing && rec) begin
      push(p, ins);
      if (m_in_post) begin
        m_left--;
        if (m_left == 0) freeze_model();
      end else if (p == trig_pc) begin
        m_trig = 1;
        if (post_cnt == 0) freeze_model();
        else begin
          m_in_post = 1;
          m_left = int'(post_cnt);
        end
      end
    end
    @(posedge clk); #1;
    trig_arm = 0; cap_en = 0;
    check_status("step");
    if (!was_frozen) check("step_rd_valid", rd_valid, 0);
  endtask

  task automatic drain(input int hold, input bit arm_pulse);
    int idx, cyc, n, hold_left;
    bit have_held;
    logic [31:0] hpc, hins;
    idx = 0; cyc = 0; have_held = 0; n = mq.size(); hold_left = hold;
    while (idx < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      trig_arm = arm_pulse && (cyc == 2);
      cap_en = 1'($urandom_range(0, 1));
      pc = trig_pc; next_pc = 32'h100; instr = $urandom;
      if (rd_valid) begin
        if (have_held) begin
          check("hold_pc", rd_pc, hpc);
          check("hold_instr", rd_instr, hins);
        end
        if (hold_left > 0) begin
          rd_ready = 0;
          hold_left--;
        end else begin
          rd_ready = 1'($urandom_range(0, 1));
        end
        if (rd_ready) begin
          check("beat_pc", rd_pc, mq[idx].pc);
          check("beat_instr", rd_instr, mq[idx].instr);
          check("beat_last", rd_last, idx == n - 1);
          idx++;
          have_held = 0;
        end else begin
          have_held = 1;
          hpc = rd_pc;
          hins = rd_instr;
        end
      end else begin
        rd_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
    end
    check("drain_beats", idx, n);
    @(negedge clk);
    rd_ready = 0; trig_arm = 0; cap_en = 0;
    mq.delete();
    m_frozen = 0;
    check("drain_rd_valid", rd_valid, 0);
    check_status("drained");
  endtask

  initial begin
    logic [31:0] p, npc;
    reset = 1; cap_en = 0; trig_arm = 0; rd_ready = 0;
    pc = 0; instr = 0; next_pc = 0; trig_pc = 0; post_cnt = 0;
    m_capturing = 0; m_in_post = 0; m_frozen = 0; m_trig = 0; m_wrapped = 0; m_left = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_pc", rd_pc, 0);
    check("rst_rd_instr", rd_instr, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_busy", busy, 0);
    check("rst_triggered", triggered, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_count", count, 0);
    reset = 0;

    // Basic capture, no wrap.
    trig_pc = 16; post_cnt = 0;
    step(0, 0, 0, 1);
    for (int i = 0; i <= 16; i += 4) step(1, i, i + 4, 0);
    drain(0, 0);

    // Wrap; a re-arm attempt while frozen must be ignored.
    trig_pc = 44; post_cnt = 0;
    step(0, 0, 0, 1);
    for (int i = 0; i <= 44; i += 4) step(1, i, i + 4, 0);
    drain(0, 1);

    // Post-trigger window with backpressure on the first beat.
    trig_pc = 8; post_cnt = 3;
    step(0, 0, 0, 1);
    for (int i = 0; i <= 24; i += 4) step(1, i, i + 4, 0);
    drain(3, 0);

    // Re-arm during POST discards the pending trigger.
    trig_pc = 8; post_cnt = 5;
    step(0, 0, 0, 1);
    for (int i = 0; i <= 12; i += 4) step(1, i, i + 4, 0);
    step(0, 0, 0, 1);
    step(1, 100, 104, 0);
    step(1, 104, 108, 0);
    post_cnt = 0;
    step(1, 8, 12, 0);
    drain(0, 0);

    // Reset abandons an armed capture.
    trig_pc = 200; post_cnt = 2;
    step(0, 0, 0, 1);
    step(1, 0, 4, 0);
    step(1, 4, 8, 0);
    do_reset();

    // Filter pattern: one discontinuity (8 -> 40) plus the trigger record.
    trig_pc = 44; post_cnt = 0;
    step(0, 0, 0, 1);
    step(1, 0, 4, 0);
    step(1, 4, 8, 0);
    step(1, 8, 40, 0);
    step(1, 40, 44, 0);
    step(1, 44, 48, 0);
    drain(0, 0);

    // Randomized rounds, including post_cnt beyond DEPTH and arms on match cycles.
    for (int r = 0; r < 12; r++) begin
      trig_pc = 32'($urandom_range(0, 15)) * 4;
      post_cnt = 4'($urandom_range(0, 15));
      step(0, 0, 0, 1);
      for (int s = 0; s < 600 && !m_frozen; s++) begin
        p = ($urandom_range(0, 7) == 0) ? trig_pc : 32'($urandom_range(0, 15)) * 4;
        npc = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) * 4 : p + 4;
        step(1'($urandom_range(0, 3) != 0), p, npc, $urandom_range(0, 39) == 0);
      end
      if (m_frozen) drain($urandom_range(0, 2), 0);
      else do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
